// File: rtl/anc_pkg.sv
// Shared constants and FSM state encoding for the ANC FIR sequencer.
package anc_pkg;

  localparam int unsigned ANC_DATA_W    = 11;
  localparam int unsigned ANC_NUM_TAPS  = 32;
  localparam int unsigned ANC_ADDR_W    = 5;
  localparam int unsigned ANC_DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    st_idle     = 3'd0,
    st_write    = 3'd1,
    st_clear    = 3'd2,
    st_mac_addr = 3'd3,
    st_mac_en   = 3'd4,
    st_drain    = 3'd5
  } anc_state_e;

endpackage

// File: rtl/anc_tap_addr_gen.sv
// Circular write pointer, tap counter and (newest - k) delay-line read address.
module anc_tap_addr_gen
  import anc_pkg::*;
#(
  parameter int unsigned NUM_TAPS = ANC_NUM_TAPS,
  parameter int unsigned ADDR_W   = ANC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_step_i,
  input  logic              tap_clr_i,
  input  logic              tap_step_i,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [ADDR_W-1:0] tap_o,
  output logic [ADDR_W-1:0] rd_addr_c,
  output logic              last_tap_c
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] newest_q, newest_d;
  logic [ADDR_W-1:0] tap_q, tap_d;

  // Next-state for pointer, newest-sample address and tap index.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    newest_d = newest_q;
    tap_d    = tap_q;
    if (wr_step_i) begin
      newest_d = wr_ptr_q;
      wr_ptr_d = (wr_ptr_q == ADDR_W'(NUM_TAPS - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
    end
    if (tap_clr_i) begin
      tap_d = '0;
    end else if (tap_step_i) begin
      tap_d = tap_q + ADDR_W'(1);
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      newest_q <= '0;
      tap_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      newest_q <= newest_d;
      tap_q    <= tap_d;
    end
  end

  assign wr_ptr_o   = wr_ptr_q;
  assign tap_o      = tap_q;
  assign rd_addr_c  = newest_q - tap_q;
  assign last_tap_c = (tap_q == ADDR_W'(NUM_TAPS - 1));

endmodule

// File: rtl/anc_filter_sequencer.sv
// Per-sample sequencer for the ANC FIR MAC datapath: write, clear, tap walk, capture.
module anc_filter_sequencer
  import anc_pkg::*;
#(
  parameter int unsigned NUM_TAPS  = ANC_NUM_TAPS,
  parameter int unsigned ADDR_W    = ANC_ADDR_W,
  parameter int unsigned DATA_W    = ANC_DATA_W,
  parameter int unsigned DRAIN_CYC = ANC_DRAIN_CYC
) (
  input  logic              Clk_100M,
  input  logic              Reset_n,
  input  logic              Enable_In,
  input  logic              Sample_Strobe,
  input  logic [DATA_W-1:0] Sample_In,
  input  logic              Clr_Overrun,
  output logic              DL_WrEn,
  output logic [ADDR_W-1:0] DL_WrAddr,
  output logic [DATA_W-1:0] DL_WrData,
  output logic [ADDR_W-1:0] DL_RdAddr,
  output logic [ADDR_W-1:0] Coef_RdAddr,
  output logic              Filter_EN_Out,
  output logic              Synch_Out,
  input  logic [DATA_W-1:0] Filt_In,
  output logic [DATA_W-1:0] Filt_Out,
  output logic              Filt_Valid,
  output logic              Busy_Out,
  output logic              Overrun_Out
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  anc_state_e         state_q;
  logic [DATA_W-1:0]  sample_q;
  logic [DRAIN_W-1:0] drain_q;

  logic              abort;
  logic              wr_step;
  logic              tap_clr;
  logic              tap_step;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] tap;
  logic [ADDR_W-1:0] rd_addr;
  logic              last_tap;

  anc_tap_addr_gen #(
    .NUM_TAPS (NUM_TAPS),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk        (Clk_100M),
    .rst_n      (Reset_n),
    .wr_step_i  (wr_step),
    .tap_clr_i  (tap_clr),
    .tap_step_i (tap_step),
    .wr_ptr_o   (wr_ptr),
    .tap_o      (tap),
    .rd_addr_c  (rd_addr),
    .last_tap_c (last_tap)
  );

  // Address-generator controls; an abort suppresses them so state is not disturbed.
  always_comb begin
    abort    = !Enable_In && (state_q != st_idle);
    wr_step  = 1'b0;
    tap_clr  = 1'b0;
    tap_step = 1'b0;
    if (!abort) begin
      case (state_q)
        st_write:  wr_step  = 1'b1;
        st_clear:  tap_clr  = 1'b1;
        st_mac_en: tap_step = !last_tap;
        default:   ;
      endcase
    end
  end

  // Sequencer FSM with registered outputs and sticky overrun flag.
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= st_idle;
      sample_q      <= '0;
      drain_q       <= '0;
      DL_WrEn       <= 1'b0;
      DL_WrAddr     <= '0;
      DL_WrData     <= '0;
      DL_RdAddr     <= '0;
      Coef_RdAddr   <= '0;
      Filter_EN_Out <= 1'b0;
      Synch_Out     <= 1'b0;
      Filt_Out      <= '0;
      Filt_Valid    <= 1'b0;
      Busy_Out      <= 1'b0;
      Overrun_Out   <= 1'b0;
    end else begin
      DL_WrEn       <= 1'b0;
      Synch_Out     <= 1'b0;
      Filter_EN_Out <= 1'b0;
      Filt_Valid    <= 1'b0;

      // A strobe seen in any non-idle state is dropped; setting beats clearing.
      if (Sample_Strobe && (state_q != st_idle)) begin
        Overrun_Out <= 1'b1;
      end else if (Clr_Overrun) begin
        Overrun_Out <= 1'b0;
      end

      if (abort) begin
        state_q  <= st_idle;
        Busy_Out <= 1'b0;
      end else begin
        case (state_q)
          st_idle: begin
            if (Sample_Strobe && Enable_In) begin
              sample_q <= Sample_In;
              state_q  <= st_write;
              Busy_Out <= 1'b1;
            end
          end
          st_write: begin
            DL_WrEn   <= 1'b1;
            DL_WrAddr <= wr_ptr;
            DL_WrData <= sample_q;
            state_q   <= st_clear;
          end
          st_clear: begin
            Synch_Out <= 1'b1;
            state_q   <= st_mac_addr;
          end
          st_mac_addr: begin
            Coef_RdAddr <= tap;
            DL_RdAddr   <= rd_addr;
            state_q     <= st_mac_en;
          end
          st_mac_en: begin
            Filter_EN_Out <= 1'b1;
            if (last_tap) begin
              drain_q <= '0;
              state_q <= st_drain;
            end else begin
              state_q <= st_mac_addr;
            end
          end
          st_drain: begin
            if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
              Filt_Out   <= Filt_In;
              Filt_Valid <= 1'b1;
              Busy_Out   <= 1'b0;
              state_q    <= st_idle;
            end else begin
              drain_q <= drain_q + DRAIN_W'(1);
            end
          end
          default: begin
            Busy_Out <= 1'b0;
            state_q  <= st_idle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anc_filter_sequencer.sv
// Directed bench for anc_filter_sequencer with hand-derived edge timing.
module tb_anc_filter_sequencer;

  localparam int unsigned NT = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 11;
  localparam int unsigned DC = 2;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          Enable_In;
  logic          Sample_Strobe;
  logic [DW-1:0] Sample_In;
  logic          Clr_Overrun;
  logic          DL_WrEn;
  logic [AW-1:0] DL_WrAddr;
  logic [DW-1:0] DL_WrData;
  logic [AW-1:0] DL_RdAddr;
  logic [AW-1:0] Coef_RdAddr;
  logic          Filter_EN_Out;
  logic          Synch_Out;
  logic [DW-1:0] Filt_In;
  logic [DW-1:0] Filt_Out;
  logic          Filt_Valid;
  logic          Busy_Out;
  logic          Overrun_Out;

  anc_filter_sequencer #(
    .NUM_TAPS  (NT),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DRAIN_CYC (DC)
  ) dut (
    .Clk_100M      (clk),
    .Reset_n       (Reset_n),
    .Enable_In     (Enable_In),
    .Sample_Strobe (Sample_Strobe),
    .Sample_In     (Sample_In),
    .Clr_Overrun   (Clr_Overrun),
    .DL_WrEn       (DL_WrEn),
    .DL_WrAddr     (DL_WrAddr),
    .DL_WrData     (DL_WrData),
    .DL_RdAddr     (DL_RdAddr),
    .Coef_RdAddr   (Coef_RdAddr),
    .Filter_EN_Out (Filter_EN_Out),
    .Synch_Out     (Synch_Out),
    .Filt_In       (Filt_In),
    .Filt_Out      (Filt_Out),
    .Filt_Valid    (Filt_Valid),
    .Busy_Out      (Busy_Out),
    .Overrun_Out   (Overrun_Out)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Per-operation observations.
  int            wr_cnt, wr_edge, syn_cnt, syn_edge, en_cnt, en_bad, busy_bad;
  int            fv_cnt, fv_edge;
  logic          ov_seen, drop_busy, drop_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, fv_data;
  logic [AW-1:0] rd_seq [NT];
  logic [AW-1:0] cf_seq [NT];

  // Count one comparison and report it if it does not match.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe a sample (edge 0), then watch ncyc edges with optional mid-op stimulus.
  task automatic run_op(input logic [DW-1:0] smp, input logic [DW-1:0] fin, input int ncyc,
                        input int strobe_edge, input int clr_edge, input int drop_edge);
    int   last_edge;
    logic exp_en;
    last_edge = (drop_edge >= 0) ? drop_edge : 68;
    wr_cnt = 0; wr_edge = -1; syn_cnt = 0; syn_edge = -1; en_cnt = 0; en_bad = 0;
    busy_bad = 0; fv_cnt = 0; fv_edge = -1; ov_seen = 1'b0; drop_busy = 1'b1; drop_en = 1'b1;
    wr_addr = '1; wr_data = '0; fv_data = '0;
    @(negedge clk);
    Enable_In = 1'b1; Sample_Strobe = 1'b1; Sample_In = smp; Filt_In = fin;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      Sample_Strobe = (c == strobe_edge);
      Clr_Overrun   = (c == clr_edge);
      Enable_In     = !(drop_edge >= 0 && c >= drop_edge);
      @(posedge clk);
      #1;
      if (DL_WrEn) begin wr_cnt++; wr_edge = c; wr_addr = DL_WrAddr; wr_data = DL_WrData; end
      if (Synch_Out) begin syn_cnt++; syn_edge = c; end
      exp_en = (c >= 4) && (c <= 66) && (c % 2 == 0) && (c < last_edge);
      if (Filter_EN_Out !== exp_en) en_bad++;
      if (Filter_EN_Out) begin
        if (en_cnt < NT) begin rd_seq[en_cnt] = DL_RdAddr; cf_seq[en_cnt] = Coef_RdAddr; end
        en_cnt++;
      end
      if (Busy_Out !== (c < last_edge)) busy_bad++;
      if (Filt_Valid) begin fv_cnt++; fv_edge = c; fv_data = Filt_Out; end
      if (Overrun_Out) ov_seen = 1'b1;
      if (c == drop_edge) begin drop_busy = Busy_Out; drop_en = Filter_EN_Out; end
    end
    @(negedge clk);
    Sample_Strobe = 1'b0;
    Clr_Overrun   = 1'b0;
  endtask

  initial begin
    int walk_bad, loop_addr_bad, loop_fv_bad, loop_ov;
    Reset_n = 1'b0; Enable_In = 1'b0; Sample_Strobe = 1'b0; Sample_In = '0;
    Clr_Overrun = 1'b0; Filt_In = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_busy",    32'(Busy_Out), 32'd0);
    chk("rst_wren",    32'(DL_WrEn), 32'd0);
    chk("rst_en",      32'(Filter_EN_Out), 32'd0);
    chk("rst_synch",   32'(Synch_Out), 32'd0);
    chk("rst_filtout", 32'(Filt_Out), 32'd0);
    chk("rst_overrun", 32'(Overrun_Out), 32'd0);
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // First sample: full timing.
    run_op(11'h155, 11'h3A0, 72, -1, -1, -1);
    chk("op1_wr_cnt",  32'(wr_cnt), 32'd1);
    chk("op1_wr_edge", 32'(wr_edge), 32'd1);
    chk("op1_wr_addr", 32'(wr_addr), 32'd0);
    chk("op1_wr_data", 32'(wr_data), 32'h155);
    chk("op1_syn_cnt", 32'(syn_cnt), 32'd1);
    chk("op1_syn_edge", 32'(syn_edge), 32'd2);
    chk("op1_en_cnt",  32'(en_cnt), 32'd32);
    chk("op1_en_bad",  32'(en_bad), 32'd0);
    chk("op1_busy_bad", 32'(busy_bad), 32'd0);
    chk("op1_fv_cnt",  32'(fv_cnt), 32'd1);
    chk("op1_fv_edge", 32'(fv_edge), 32'd68);
    chk("op1_fv_data", 32'(fv_data), 32'h3A0);
    chk("op1_overrun", 32'(ov_seen), 32'd0);

    // Second sample, negative filter output.
    repeat (7) @(negedge clk);
    run_op(11'h2AA, 11'h7FF, 72, -1, -1, -1);
    chk("op2_wr_addr", 32'(wr_addr), 32'd1);
    chk("op2_wr_data", 32'(wr_data), 32'h2AA);
    chk("op2_filtout", 32'(Filt_Out), 32'h7FF);

    // Third sample: address walk from newest=2.
    repeat (7) @(negedge clk);
    run_op(11'h001, 11'h123, 72, -1, -1, -1);
    chk("op3_wr_addr", 32'(wr_addr), 32'd2);
    walk_bad = 0;
    for (int k = 0; k < int'(NT); k++) begin
      if (rd_seq[k] !== AW'(2 - k)) walk_bad++;
      if (cf_seq[k] !== AW'(k)) walk_bad++;
    end
    chk("op3_walk_bad", 32'(walk_bad), 32'd0);
    chk("op3_rd_k3",  32'(rd_seq[3]), 32'd31);
    chk("op3_rd_k31", 32'(rd_seq[31]), 32'd3);

    // Samples 4..33, 80 cycles apart: pointer wraps, no overrun.
    loop_addr_bad = 0; loop_fv_bad = 0; loop_ov = 0;
    for (int i = 4; i <= 33; i++) begin
      repeat (7) @(negedge clk);
      run_op(DW'(i * 37), DW'(i * 13), 72, -1, -1, -1);
      if (wr_addr !== AW'(i - 1)) loop_addr_bad++;
      if (fv_cnt != 1 || fv_data !== DW'(i * 13)) loop_fv_bad++;
      if (ov_seen) loop_ov++;
    end
    chk("op33_wr_addr",  32'(wr_addr), 32'd0);
    chk("loop_addr_bad", 32'(loop_addr_bad), 32'd0);
    chk("loop_fv_bad",   32'(loop_fv_bad), 32'd0);
    chk("loop_overrun",  32'(loop_ov), 32'd0);

    // Strobe while disabled in idle: ignored, no overrun.
    @(negedge clk); Enable_In = 1'b0; Sample_Strobe = 1'b1;
    @(negedge clk); Sample_Strobe = 1'b0;
    @(negedge clk);
    chk("dis_busy",    32'(Busy_Out), 32'd0);
    chk("dis_overrun", 32'(Overrun_Out), 32'd0);

    // Strobe at edge 20 with a simultaneous clear: set wins, op completes.
    run_op(11'h0AB, 11'h0F0, 72, 20, 20, -1);
    chk("ovr_seen",     32'(ov_seen), 32'd1);
    chk("ovr_sticky",   32'(Overrun_Out), 32'd1);
    chk("ovr_wr_cnt",   32'(wr_cnt), 32'd1);
    chk("ovr_wr_addr",  32'(wr_addr), 32'd1);
    chk("ovr_fv_edge",  32'(fv_edge), 32'd68);
    chk("ovr_fv_data",  32'(fv_data), 32'h0F0);
    chk("ovr_busy_bad", 32'(busy_bad), 32'd0);
    @(negedge clk); Clr_Overrun = 1'b1;
    @(negedge clk); Clr_Overrun = 1'b0;
    chk("ovr_cleared", 32'(Overrun_Out), 32'd0);

    // Strobe on the edge the FSM returns to idle: dropped and flagged.
    repeat (5) @(negedge clk);
    run_op(11'h0CD, 11'h246, 72, 68, -1, -1);
    chk("edge68_overrun",  32'(ov_seen), 32'd1);
    chk("edge68_busy_bad", 32'(busy_bad), 32'd0);
    chk("edge68_fv_edge",  32'(fv_edge), 32'd68);
    chk("edge68_wr_addr",  32'(wr_addr), 32'd2);
    @(negedge clk); Clr_Overrun = 1'b1;
    @(negedge clk); Clr_Overrun = 1'b0;
    chk("edge68_cleared", 32'(Overrun_Out), 32'd0);

    // Enable dropped during MAC_EN of tap 10: abort.
    repeat (5) @(negedge clk);
    run_op(11'h0EE, 11'h555, 72, -1, -1, 24);
    chk("abort_wr_addr",  32'(wr_addr), 32'd3);
    chk("abort_busy",     32'(drop_busy), 32'd0);
    chk("abort_en",       32'(drop_en), 32'd0);
    chk("abort_en_cnt",   32'(en_cnt), 32'd10);
    chk("abort_en_bad",   32'(en_bad), 32'd0);
    chk("abort_busy_bad", 32'(busy_bad), 32'd0);
    chk("abort_fv_cnt",   32'(fv_cnt), 32'd0);
    chk("abort_filtout",  32'(Filt_Out), 32'h246);

    repeat (5) @(negedge clk);
    run_op(11'h111, 11'h135, 72, -1, -1, -1);
    chk("post_abort_wr_addr", 32'(wr_addr), 32'd4);
    chk("post_abort_fv_data", 32'(fv_data), 32'h135);

    // Async reset during DRAIN, between clock edges.
    repeat (5) @(negedge clk);
    run_op(11'h222, 11'h333, 66, 20, -1, -1);
    chk("pre_rst_overrun", 32'(Overrun_Out), 32'd1);
    chk("pre_rst_busy",    32'(Busy_Out), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_busy",    32'(Busy_Out), 32'd0);
    chk("arst_filtout", 32'(Filt_Out), 32'd0);
    chk("arst_overrun", 32'(Overrun_Out), 32'd0);
    chk("arst_rdaddr",  32'(DL_RdAddr), 32'd0);
    chk("arst_coef",    32'(Coef_RdAddr), 32'd0);
    chk("arst_wraddr",  32'(DL_WrAddr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_op(11'h444, 11'h0AA, 72, -1, -1, -1);
    chk("post_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("post_rst_fv_data", 32'(fv_data), 32'h0AA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/anc_filter_sequencer.md
Name: anc_filter_sequencer

Overview:
- Per-sample controller for the ANC FIR multiply-accumulate datapath.
- On each new reference-mic sample it does four things in order:
  - writes the sample into a circular delay-line RAM;
  - clears the datapath accumulator;
  - walks all taps, presenting coefficient and delay-line addresses and pulsing the filter enable once per tap;
  - captures the scaled filter output.
- Sits between the ADC sample strobe, the delay-line/coefficient RAMs and the MAC filter block.

Parameters:
- NUM_TAPS, 32, number of FIR taps; power of two, 2..256.
- ADDR_W, 5, log2(NUM_TAPS); width of all RAM addresses and tap counters.
- DATA_W, 11, sample/output width, two's complement.
- DRAIN_CYC, 2, cycles waited after the last tap before capturing datapath output; minimum 1.

Ports:
- Clk_100M  in  1  system clock, all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable_In  in  1  sequencer enable, level.
- Sample_Strobe  in  1  one-cycle pulse: Sample_In valid.
- Sample_In  in  DATA_W  new reference sample.
- Clr_Overrun  in  1  clears sticky Overrun_Out.
- DL_WrEn  out  1  delay-line RAM write strobe.
- DL_WrAddr  out  ADDR_W  delay-line write address.
- DL_WrData  out  DATA_W  delay-line write data.
- DL_RdAddr  out  ADDR_W  delay-line read address; RAM has 1-cycle read latency.
- Coef_RdAddr  out  ADDR_W  coefficient RAM read address; RAM has 1-cycle read latency.
- Filter_EN_Out  out  1  MAC enable, one pulse per tap.
- Synch_Out  out  1  accumulator clear/hold to datapath.
- Filt_In  in  DATA_W  scaled datapath output.
- Filt_Out  out  DATA_W  registered filter result.
- Filt_Valid  out  1  one-cycle pulse: Filt_Out updated.
- Busy_Out  out  1  high in any state but IDLE.
- Overrun_Out  out  1  sticky: a strobe arrived while busy.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, wr_ptr=0, tap counter=0;
  - all outputs 0, including Filt_Out=0 and Overrun_Out=0.
- FSM states: IDLE, WRITE, CLEAR, MAC_ADDR, MAC_EN, DRAIN. All outputs are registered.
- IDLE: on Sample_Strobe & Enable_In, latch Sample_In and go to WRITE. A strobe while Enable_In=0 is ignored and does not count as overrun.
- WRITE (1 cycle):
  - DL_WrEn=1, DL_WrAddr=wr_ptr, DL_WrData=latched sample;
  - newest=wr_ptr;
  - wr_ptr <= wr_ptr+1 mod NUM_TAPS (wraps NUM_TAPS-1 -> 0);
  - then go to CLEAR.
- CLEAR (1 cycle): Synch_Out=1, Filter_EN_Out=0, tap k=0; then go to MAC_ADDR.
- MAC_ADDR (1 cycle): Coef_RdAddr=k, DL_RdAddr=(newest-k) mod NUM_TAPS, Filter_EN_Out=0. Addresses are held through the following MAC_EN.
- MAC_EN (1 cycle): Filter_EN_Out=1.
  - If k==NUM_TAPS-1, go to DRAIN with drain counter=0.
  - Otherwise k<=k+1 and return to MAC_ADDR.
  - Exactly NUM_TAPS enable pulses per sample; each is preceded by a low cycle, so the datapath sees a falling edge per tap.
- DRAIN (DRAIN_CYC cycles): Filter_EN_Out=0.
  - On the last drain cycle, Filt_Out<=Filt_In and Filt_Valid=1 for one cycle.
  - Go to IDLE.
- Latency: the strobe is sampled on edge 0; Filt_Valid is high in the cycle following edge 2*NUM_TAPS+DRAIN_CYC+2. With defaults this is edge 68, i.e. one sample per 69 cycles maximum.
- Overrun:
  - Sample_Strobe while Busy_Out=1 sets Overrun_Out; the strobe is dropped and the operation in progress is unaffected.
  - Clr_Overrun clears Overrun_Out. If Clr_Overrun and a new overrun occur in the same cycle, set wins.
  - A strobe in the same cycle the FSM returns to IDLE counts as busy: it is dropped and flagged.
- Enable_In falling mid-operation: abort at the next edge and go to IDLE.
  - Filter_EN_Out, Synch_Out and DL_WrEn go to 0; no Filt_Valid is issued; Filt_Out holds its old value.
  - An increment of wr_ptr already made in WRITE is kept.
- Reset mid-operation: immediate return to reset values. The delay-line RAM contents are not cleared by this block.

Decomposition:
- Shared package anc_pkg:
  - DATA_W default;
  - FSM state encoding enum (st_idle, st_write, st_clear, st_mac_addr, st_mac_en, st_drain);
  - default NUM_TAPS/ADDR_W.
- One natural sub-module: anc_tap_addr_gen, holding the modulo wr_ptr, tap counter k and the (newest-k) read-address subtractor, with load/step/last-tap outputs. The FSM stays in the top module.

Test Plan:
- Reset then a single strobe, Sample_In=11'h155, NUM_TAPS=32, DRAIN_CYC=2:
  - DL_WrEn at edge 1 with addr 0, data 11'h155;
  - Synch_Out for one cycle;
  - 32 Filter_EN_Out pulses, each one cycle wide and separated by one low cycle;
  - Filt_Valid one cycle after edge 68, Filt_Out equal to Filt_In at that cycle (drive Filt_In=11'h3A0 -> Filt_Out=11'h3A0).
- Address walk on the 3rd sample (newest=2):
  - DL_RdAddr sequence is 2,1,0,31,30,...,3;
  - Coef_RdAddr sequence is 0..31.
- 33 consecutive samples: wr_ptr wraps, the 33rd write goes to address 0, and Overrun_Out stays 0 when strobes are spaced 80 cycles apart.
- Strobe at edge 20 of an operation:
  - Overrun_Out=1 and the current Filt_Valid still occurs at edge 68;
  - no second operation starts;
  - Clr_Overrun pulse -> Overrun_Out=0.
- Enable_In dropped during MAC_EN of tap 10:
  - next cycle Busy_Out=0 and Filter_EN_Out=0;
  - no Filt_Valid;
  - the next enabled strobe writes to address wr_ptr+1.
- Reset_n asserted asynchronously mid-DRAIN: all outputs 0 immediately without waiting for a clock edge; after release the next write goes to address 0.
